neuron_step_scheduler: RTL

- Upstream sequencer for the memory-mapped neuron bank: on each timestep tick it loads every neuron's input current, pulses its update and polls status until the neuron is idle.
- It collects spikes into an output FIFO of spike events (neuron index, timestep) for the NoC packetiser.
- It replaces CPU-driven per-neuron polling, and drives the bank's addr/write/read port directly.

---
 rtl/neuron_step_scheduler_if.sv | 30 +++
 rtl/neuron_step_scheduler.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/neuron_step_scheduler_if.sv
// Bus bundle between the step scheduler, the memory-mapped neuron bank and the spike event consumer.
// Spike stream: an entry transfers on every rising edge where spike_valid && spike_ready; head fields are stable while valid && !ready.
interface neuron_step_scheduler_if #(
  parameter int NID_W = 2
);
  logic [31:0]      bank_addr;
  logic             bank_write_en;
  logic [31:0]      bank_write_data;
  logic             bank_read_en;
  logic [31:0]      bank_read_data;
  logic             bank_busywait;
  logic             spike_valid;
  logic             spike_ready;
  logic [NID_W-1:0] spike_neuron;
  logic [15:0]      spike_step;

  modport master (
    output bank_addr, bank_write_en, bank_write_data, bank_read_en,
    input  bank_read_data, bank_busywait,
    output spike_valid, spike_neuron, spike_step,
    input  spike_ready
  );

  modport slave (
    input  bank_addr, bank_write_en, bank_write_data, bank_read_en,
    output bank_read_data, bank_busywait,
    input  spike_valid, spike_neuron, spike_step,
    output spike_ready
  );
endinterface

// File: rtl/neuron_step_scheduler.sv
// Per-timestep sequencer for the neuron bank: writes current and control, polls status until idle,
// and queues spike events {neuron, timestep} in a small FIFO for the packetiser.
module neuron_step_scheduler #(
  parameter int          NUM_NEURONS    = 4,
  parameter logic [31:0] BANK_BASE      = 32'h0,
  parameter int          START_DLY      = 2,
  parameter int          TIMEOUT_CYCLES = 64,
  parameter int          FIFO_DEPTH     = 8,
  localparam int         NID_W          = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      step_start,
  input  logic [32*NUM_NEURONS-1:0] currents_in,
  input  logic [NUM_NEURONS-1:0]    mode_cfg,
  input  logic                      clear_flags,
  output logic                      step_busy,
  output logic                      step_done,
  output logic [15:0]               timestep,
  neuron_step_scheduler_if.master   bus,
  output logic                      fifo_overflow,
  output logic                      timeout_err,
  output logic                      step_missed,
  output logic [2:0]                dbg_state
);
  localparam int DLY_W    = (START_DLY > 1) ? $clog2(START_DLY + 1) : 1;
  localparam int DLY_LOAD = (START_DLY > 0) ? START_DLY - 1 : 0;
  localparam int PC_W     = $clog2(TIMEOUT_CYCLES + 1);
  localparam int AW       = $clog2(FIFO_DEPTH);

  typedef enum logic [2:0] {IDLE, WR_I, WR_CTRL, DLY, POLL, NEXT, DONE} state_t;

  state_t                    state, state_d;
  logic [NID_W-1:0]          n, n_d;
  logic [DLY_W-1:0]          dly_cnt, dly_d;
  logic [PC_W-1:0]           poll_cnt, poll_d;
  logic [32*NUM_NEURONS-1:0] cur_q, cur_src;
  logic [NUM_NEURONS-1:0]    mode_q;
  logic                      push, timeout_hit, we_d, re_d;
  logic [31:0]               addr_d, wdata_d, base_n;
  logic [NID_W+15:0]         mem [FIFO_DEPTH];
  logic [AW:0]               wr_ptr, rd_ptr;
  logic                      full, empty, pop, do_push;
  logic                      unused_rd;

  assign unused_rd = ^bus.bank_read_data[31:2];
  assign step_busy = (state != IDLE) && (state != DONE);
  assign step_done = (state == DONE);
  assign dbg_state = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  // Bank outputs are derived from the next state, so they are registered yet valid during the state itself.
  always_comb begin
    state_d     = state;
    n_d         = n;
    dly_d       = dly_cnt;
    poll_d      = poll_cnt;
    push        = 1'b0;
    timeout_hit = 1'b0;
    unique case (state)
      IDLE:    if (step_start) begin state_d = WR_I; n_d = '0; end
      WR_I:    if (!bus.bank_busywait) state_d = WR_CTRL;
      WR_CTRL: if (!bus.bank_busywait) begin
        dly_d   = DLY_W'(DLY_LOAD);
        poll_d  = '0;
        state_d = (START_DLY == 0) ? POLL : DLY;
      end
      DLY:     if (dly_cnt == '0) state_d = POLL; else dly_d = dly_cnt - 1'b1;
      POLL:    if (!bus.bank_busywait) begin
        if (!bus.bank_read_data[1]) begin
          push    = bus.bank_read_data[0];
          state_d = NEXT;
        end else if (poll_cnt == PC_W'(TIMEOUT_CYCLES - 1)) begin
          timeout_hit = 1'b1;
          state_d     = NEXT;
        end else begin
          poll_d = poll_cnt + 1'b1;
        end
      end
      NEXT:    if (n == NID_W'(NUM_NEURONS - 1)) state_d = DONE;
               else begin n_d = n + 1'b1; state_d = WR_I; end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    cur_src = (state == IDLE) ? currents_in : cur_q;
    base_n  = BANK_BASE + (32'(n_d) << 6);
    we_d    = 1'b0;
    re_d    = 1'b0;
    addr_d  = '0;
    wdata_d = '0;
    unique case (state_d)
      WR_I:    begin we_d = 1'b1; addr_d = base_n + 32'h14; wdata_d = cur_src[int'(n_d)*32 +: 32]; end
      WR_CTRL: begin we_d = 1'b1; addr_d = base_n + 32'h18; wdata_d = {29'b0, mode_q[n_d], 1'b0, 1'b1}; end
      POLL:    begin re_d = 1'b1; addr_d = base_n + 32'h1C; end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n                   <= '0;
      dly_cnt             <= '0;
      poll_cnt            <= '0;
      cur_q               <= '0;
      mode_q              <= '0;
      timestep            <= '0;
      bus.bank_addr       <= '0;
      bus.bank_write_en   <= 1'b0;
      bus.bank_write_data <= '0;
      bus.bank_read_en    <= 1'b0;
    end else begin
      n                   <= n_d;
      dly_cnt             <= dly_d;
      poll_cnt            <= poll_d;
      bus.bank_addr       <= addr_d;
      bus.bank_write_en   <= we_d;
      bus.bank_write_data <= wdata_d;
      bus.bank_read_en    <= re_d;
      if (state == IDLE && step_start) begin
        cur_q  <= currents_in;
        mode_q <= mode_cfg;
      end
      if (state == DONE) timestep <= timestep + 16'd1;
    end
  end

  // Set conditions take priority over clear_flags in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fifo_overflow <= 1'b0;
      timeout_err   <= 1'b0;
      step_missed   <= 1'b0;
    end else begin
      if (push && full && !pop)    fifo_overflow <= 1'b1;
      else if (clear_flags)        fifo_overflow <= 1'b0;
      if (timeout_hit)             timeout_err   <= 1'b1;
      else if (clear_flags)        timeout_err   <= 1'b0;
      if (step_start && step_busy) step_missed   <= 1'b1;
      else if (clear_flags)        step_missed   <= 1'b0;
    end
  end

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop     = !empty && bus.spike_ready;
  assign do_push = push && (!full || pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= {n, timestep};
  end

  assign bus.spike_valid  = !empty;
  assign bus.spike_neuron = empty ? '0 : mem[rd_ptr[AW-1:0]][NID_W+15:16];
  assign bus.spike_step   = empty ? '0 : mem[rd_ptr[AW-1:0]][15:0];
endmodule
